// File: rtl/pipechain.sv
// Elastic valid/ready register chain with per-stage valid bits, bubble collapse and synchronous flush.
// Optional PIPECHAIN_COUNT_EN adds a registered occupancy count on COUNT.
module pipechain #(
    parameter int NUM_STG = 8,
    parameter int WIDTH   = 32,
    parameter int CW      = $clog2(NUM_STG + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VLD,
    output logic             IN_RDY,
    input  logic [WIDTH-1:0] IN,
    output logic             OUT_VLD,
    input  logic             OUT_RDY,
    output logic [WIDTH-1:0] OUT
`ifdef PIPECHAIN_COUNT_EN
    ,
    output logic [CW-1:0]    COUNT
`endif
);

    if (NUM_STG < 1 || CW != $clog2(NUM_STG + 1)) begin : g_bad_cfg
        $error("pipechain: NUM_STG must be >= 1 and CW must not be overridden");
    end

    logic [NUM_STG-1:0] vld;
    logic [WIDTH-1:0]   dat [NUM_STG];
    logic [NUM_STG:0]   adv;

    // A stage may load when it is empty or its own word moves on.
    always_comb begin
        logic run;
        // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
        adv[NUM_STG] = OUT_RDY;
        run          = OUT_RDY;
        for (int k = NUM_STG - 1; k >= 0; k--) begin
            run    = !vld[k] | run;
            adv[k] = run;
        end
    end

    assign IN_RDY  = adv[0] & !FLUSH;
    assign OUT_VLD = vld[NUM_STG-1];
    assign OUT     = dat[NUM_STG-1];

    // NOTE: sequential state uses non-blocking '<=' so every stage samples pre-edge values of its neighbour.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) begin
            vld <= '0;
        end else begin
            if (adv[0]) vld[0] <= IN_VLD & IN_RDY;
            for (int k = 1; k < NUM_STG; k++) begin
                if (adv[k]) vld[k] <= vld[k-1];
            end
        end
    end

    // NOTE: data registers carry no reset; vld alone qualifies them, which keeps them retimable.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (adv[0]) dat[0] <= IN;
            for (int k = 1; k < NUM_STG; k++) begin
                if (adv[k]) dat[k] <= dat[k-1];
            end
        end
    end

`ifdef PIPECHAIN_COUNT_EN
    logic in_fire, out_fire;

    assign in_fire  = IN_VLD & IN_RDY;
    assign out_fire = OUT_VLD & OUT_RDY;

    // A departure during flush is dropped by the clear, so the count never wraps below zero.
    always_ff @(posedge CLK) begin
        if (RST || FLUSH) COUNT <= '0;
        else              COUNT <= COUNT + CW'(in_fire) - CW'(out_fire);
    end
`endif

endmodule

// File: doc/pipechain.md
# pipechain

Elastic, parametrised pipeline chain: NUM_STG register stages of WIDTH bits, each with its own valid bit. A valid/ready handshake runs on both ends. Bubbles collapse under backpressure, and a synchronous flush is provided. It is the drop-in successor to the fixed register chain in datapaths such as the dot-product pipeline, wherever the downstream consumer can stall. Data registers are not reset, which keeps them free for retiming; only the valid bits are reset.

## Interface
Parameters:
- NUM_STG, default 8: number of register stages; legal range ≥ 1.
- WIDTH, default 32: data width in bits.
- CW, default $clog2(NUM_STG+1): width of COUNT (derived; do not override).

Ports:
- CLK  input  1  single clock; all state updates on its rising edge.
- RST  input  1  reset, synchronous, active-high.
- FLUSH  input  1  synchronous clear of all valid bits.
- IN_VLD  input  1  upstream word valid.
- IN_RDY  output  1  chain can accept a word this cycle.
- IN  input  WIDTH  upstream data.
- OUT_VLD  output  1  output stage holds a valid word.
- OUT_RDY  input  1  downstream accepts the output word this cycle.
- OUT  output  WIDTH  output data, driven by stage NUM_STG-1.
- COUNT  output  CW  number of valid stages; present only with PIPECHAIN_COUNT_EN.

## Operation
- State per stage k, for k = 0..NUM_STG-1: vld[k] and dat[k]. Stage 0 is the input side; stage NUM_STG-1 drives OUT and OUT_VLD.
- Advance condition, combinational: adv[NUM_STG] = OUT_RDY, and adv[k] = !vld[k] | adv[k+1].
- IN_RDY = adv[0] & !FLUSH.
- On each edge where adv[k] = 1:
  - For k > 0: vld[k] <= vld[k-1] and dat[k] <= dat[k-1].
  - For stage 0: vld[0] <= IN_VLD & IN_RDY, and dat[0] <= IN.
- Stages with adv[k] = 0 hold both data and valid.
- Bubble collapse: an empty stage always accepts from the stage before it. Under a stall, words compact toward the output, so the chain can hold NUM_STG words.
- The transfer rules are standard: a word is taken in when IN_VLD & IN_RDY and leaves when OUT_VLD & OUT_RDY. OUT_RDY with OUT_VLD = 0 is legal and has no effect.
- Upstream may drop IN_VLD or change IN while IN_RDY = 0; the chain does not require upstream to hold its word.
- FLUSH = 1: all vld[k] <= 0 at the next edge and no input is accepted that cycle (IN_RDY = 0). The word currently on OUT may still be consumed in the flush cycle if OUT_RDY = 1.
- Priority: RST > FLUSH > normal advance.
- RST: all vld[k] <= 0; dat[k] is left unchanged.
- Reset values:
  - OUT_VLD = 0 and COUNT = 0.
  - IN_RDY = 1 once RST and FLUSH are low, because the chain is empty.
  - OUT is undefined and must not be interpreted while OUT_VLD = 0.
- Ordering: words leave in the order they were accepted. There is no duplication and no loss except by FLUSH or RST.

## Timing
- Latency: a word accepted in cycle c appears on OUT with OUT_VLD = 1 in cycle c+NUM_STG, provided no stage along its path stalls. This equals the legacy fixed-chain latency.
- Throughput: 1 word per cycle while OUT_RDY = 1.
- IN_RDY depends combinationally on OUT_RDY through the adv chain; there is no register on the ready path.
- Full chain (all vld = 1):
  - With OUT_RDY = 1, IN_RDY = 1: one word leaves and one enters in the same cycle, and COUNT is unchanged.
  - With OUT_RDY = 0, IN_RDY = 0.
- Empty chain: OUT_VLD = 0, IN_RDY = 1, and the OUT_RDY value is irrelevant.
- NUM_STG = 1 behaves as a single register with handshake: IN_RDY = !vld[0] | OUT_RDY.
- Reset mid-operation: all in-flight words are discarded at the RST edge. In the next cycle OUT_VLD = 0 and IN_RDY = 1, provided FLUSH is low.

## Configuration
- PIPECHAIN_COUNT_EN defined:
  - The COUNT port exists and is registered.
  - Next-cycle COUNT = COUNT + (IN_VLD & IN_RDY) − (OUT_VLD & OUT_RDY), saturating at neither end; consistency is guaranteed by the handshake.
  - COUNT is cleared to 0 by RST or FLUSH. A departure in the flush cycle does not make COUNT go below 0.
- PIPECHAIN_COUNT_EN undefined: the COUNT port and its counter logic are absent. All other behaviour is identical.

## Test plan
- Latency: NUM_STG=4, WIDTH=32, OUT_RDY=1, drive IN=0xA5A5_0001 with IN_VLD for one cycle in cycle 10 -> OUT_VLD=1 and OUT=0xA5A5_0001 in cycle 14 only.
- Stall fill: NUM_STG=4, OUT_RDY=0, stream 1,2,3,4,5 -> IN_RDY falls after 4 acceptances, COUNT=4, word 5 is held off. Raise OUT_RDY -> outputs 1,2,3,4,5 in consecutive cycles, and word 5 is accepted in the same cycle word 1 leaves.
- Bubble collapse: NUM_STG=8, sparse input (1 word every 3 cycles) for 6 words, then OUT_RDY=0 -> all 6 words compact, IN_RDY stays 1 until 8 are held, and output order is preserved.
- Flush: NUM_STG=4, 3 words in flight, FLUSH=1 for one cycle with IN_VLD=1 -> IN_RDY=0 in that cycle. Next cycle OUT_VLD=0, COUNT=0, and no flushed word ever appears.
- Reset mid-stream: continuous stream, RST=1 for one cycle at cycle 20 -> cycle 21 has OUT_VLD=0 and IN_RDY=1. A new word accepted in cycle 21 appears in cycle 21+NUM_STG.
- Random soak: random IN_VLD/OUT_RDY, NUM_STG ∈ {1,3,8}, 10k cycles, against a scoreboard FIFO -> exact in-order match, and COUNT equals the scoreboard depth every cycle.
